// File: rtl/video_pkg.sv
// Shared timing defaults, counter width, FSM encoding and RGB888 packing
// for the DVI raster path.
package video_pkg;

   localparam int CNT_W = 12;
   localparam int PIX_W = 24;

   // RGB888 packing: {R, G, B}
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   // 640x480@60 defaults
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit DEF_HSYNC_POL = 1'b0;
   localparam bit DEF_VSYNC_POL = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   function automatic logic [7:0] pix_chan(input logic [PIX_W-1:0] pix, input int lsb);
      return pix[lsb +: 8];
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active, sync and frame-boundary decode.
// Counters hold when advance_i is low; the controller keeps them at 0 while idle.
module video_timing_counter
   import video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic advance_i,
   output logic active_o,
   output logic hsync_o,
   output logic vsync_o,
   output logic frame_first_o,
   output logic frame_last_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_last;
   logic             v_last;

   assign h_last = (h_cnt == H_LAST_C);
   assign v_last = (v_cnt == V_LAST_C);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (advance_i) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign active_o      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign hsync_o       = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
   assign vsync_o       = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);
   assign frame_first_o = (h_cnt == '0) && (v_cnt == '0);
   assign frame_last_o  = h_last && v_last;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing controller: frame-aligned start/stop FSM, one-pixel-per-clock
// pull from the upstream source, registered RGB/sync/blank and sticky underflow.
module video_timing_ctrl
   import video_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit HSYNC_POL = DEF_HSYNC_POL,
   parameter bit VSYNC_POL = DEF_VSYNC_POL
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             pix_valid_i,
   input  logic [PIX_W-1:0] pix_data_i,
   output logic             pix_ready_o,
   output logic [7:0]       vga_red_o,
   output logic [7:0]       vga_green_o,
   output logic [7:0]       vga_blue_o,
   output logic             vga_blank_o,
   output logic             vga_hsync_o,
   output logic             vga_vsync_o,
   output logic             frame_start_o,
   output logic             busy_o,
   output logic             underflow_o
);

   state_t state_q;
   state_t state_d;
   logic   busy;
   logic   active;
   logic   hsync;
   logic   vsync;
   logic   frame_first;
   logic   frame_last;
   logic   pix_live;
   logic   pix_take;
   logic   pix_starve;
   logic   frame_begin;

   video_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_counter (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .advance_i     (busy),
      .active_o      (active),
      .hsync_o       (hsync),
      .vsync_o       (vsync),
      .frame_first_o (frame_first),
      .frame_last_o  (frame_last)
   );

   assign busy        = (state_q != ST_IDLE);
   assign busy_o      = busy;
   assign pix_live    = busy && active;
   assign pix_ready_o = pix_live;
   assign pix_take    = pix_live && pix_valid_i;
   assign pix_starve  = pix_live && !pix_valid_i;
   assign frame_begin = busy && frame_first;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // A stop request on the very last cycle of a frame goes straight to idle,
   // so no extra frame is started just to be drained.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (enable_i) state_d = ST_RUN;
         ST_RUN:      if (!enable_i) state_d = frame_last ? ST_IDLE : ST_STOPPING;
         ST_STOPPING: begin
            if (enable_i)        state_d = ST_RUN;
            else if (frame_last) state_d = ST_IDLE;
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vga_red_o     <= '0;
         vga_green_o   <= '0;
         vga_blue_o    <= '0;
         vga_blank_o   <= 1'b1;
         vga_hsync_o   <= ~HSYNC_POL;
         vga_vsync_o   <= ~VSYNC_POL;
         frame_start_o <= 1'b0;
         underflow_o   <= 1'b0;
      end else begin
         vga_red_o     <= pix_take ? pix_chan(pix_data_i, R_LSB) : 8'h00;
         vga_green_o   <= pix_take ? pix_chan(pix_data_i, G_LSB) : 8'h00;
         vga_blue_o    <= pix_take ? pix_chan(pix_data_i, B_LSB) : 8'h00;
         vga_blank_o   <= !pix_live;
         vga_hsync_o   <= (busy && hsync) ? HSYNC_POL : ~HSYNC_POL;
         vga_vsync_o   <= (busy && vsync) ? VSYNC_POL : ~VSYNC_POL;
         frame_start_o <= frame_begin;
         // set beats the frame-start clear
         if (pix_starve)       underflow_o <= 1'b1;
         else if (frame_begin) underflow_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a shrunken raster (15x8 clocks per frame)
// against a frame-position model.
module tb_video_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [23:0] pix_data_i = '0;
  logic        pix_ready_o;
  logic [7:0]  vga_red_o, vga_green_o, vga_blue_o;
  logic        vga_blank_o, vga_hsync_o, vga_vsync_o;
  logic        frame_start_o, busy_o, underflow_o;

  always #5 clk_i = ~clk_i;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
    .vga_red_o(vga_red_o), .vga_green_o(vga_green_o), .vga_blue_o(vga_blue_o),
    .vga_blank_o(vga_blank_o), .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o),
    .frame_start_o(frame_start_o), .busy_o(busy_o), .underflow_o(underflow_o)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode 0 = idle, 1 = running, 2 = stopping; m_pos = linear position in frame
  int          m_mode = 0;
  int          m_pos = 0;
  int          m_h, m_v;
  bit          m_busy, m_act, m_last;
  logic        e_blank = 1'b1, e_hs = ~HPOL, e_vs = ~VPOL, e_fs = 1'b0, e_und = 1'b0;
  logic [23:0] exp_q[$];

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_mode = 0; m_pos = 0;
      e_blank = 1'b1; e_hs = ~HPOL; e_vs = ~VPOL; e_fs = 1'b0; e_und = 1'b0;
      exp_q.delete();
    end else begin
      m_h = m_pos % HT;
      m_v = m_pos / HT;
      m_busy = (m_mode != 0);
      m_act  = m_busy && (m_h < HA) && (m_v < VA);
      e_blank = !m_act;
      e_hs = (m_busy && m_h >= HA + HF && m_h < HA + HF + HS) ? HPOL : ~HPOL;
      e_vs = (m_busy && m_v >= VA + VF && m_v < VA + VF + VS) ? VPOL : ~VPOL;
      e_fs = m_busy && (m_pos == 0);
      if (m_act && !pix_valid_i) e_und = 1'b1;
      else if (e_fs)             e_und = 1'b0;
      if (m_act) exp_q.push_back(pix_valid_i ? pix_data_i : 24'h0);
      m_last = (m_pos == FRAME - 1);
      case (m_mode)
        0: if (enable_i) m_mode = 1;
        1: if (!enable_i) m_mode = m_last ? 0 : 2;
        default: begin
          if (enable_i)    m_mode = 1;
          else if (m_last) m_mode = 0;
        end
      endcase
      if (m_busy) m_pos = (m_pos + 1) % FRAME;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [23:0] exp_pix;
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("blank", vga_blank_o, e_blank);
      chk("hsync", vga_hsync_o, e_hs);
      chk("vsync", vga_vsync_o, e_vs);
      chk("frame_start", frame_start_o, e_fs);
      chk("underflow", underflow_o, e_und);
      chk("busy", busy_o, m_mode != 0);
      chk("pix_ready", pix_ready_o,
          (m_mode != 0) && (m_pos % HT < HA) && (m_pos / HT < VA));
      if (!e_blank) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rgb_queue: got pixel %0h expected none queued", {vga_red_o, vga_green_o, vga_blue_o});
        end else begin
          exp_pix = exp_q.pop_front();
          chk("rgb", {vga_red_o, vga_green_o, vga_blue_o}, exp_pix);
        end
      end else begin
        chk("rgb_blank", {vga_red_o, vga_green_o, vga_blue_o}, 24'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int valid_mode = 0;   // 0 always valid, 1 random, 2 ramp (data = h index)
  bit drop_en = 1'b0;
  bit rand_en = 1'b0;
  int cyc = 0;

  task automatic drive_cycle();
    @(negedge clk_i);
    cyc++;
    case (valid_mode)
      1: begin
        pix_valid_i = ($urandom_range(9, 0) != 0);
        pix_data_i  = 24'($urandom());
      end
      2: begin
        pix_valid_i = 1'b1;
        pix_data_i  = 24'(m_pos % HT);
      end
      default: begin
        pix_valid_i = 1'b1;
        pix_data_i  = 24'($urandom());
      end
    endcase
    if (drop_en && m_pos >= 2 * HT + 3 && m_pos <= 2 * HT + 5) pix_valid_i = 1'b0;
    if (rand_en && $urandom_range(99, 0) == 0) enable_i = ~enable_i;
  endtask

  task automatic wait_pos(input int p, input int budget);
    for (int i = 0; i < budget; i++) begin
      drive_cycle();
      if (m_mode != 0 && m_pos == p) return;
    end
    checks++; failures++;
    $display("FAIL wait_pos: position %0d not reached within %0d cycles", p, budget);
  endtask

  task automatic wait_fs(input int budget);
    for (int i = 0; i < budget; i++) begin
      drive_cycle();
      if (frame_start_o) return;
    end
    checks++; failures++;
    $display("FAIL wait_fs: no frame_start within %0d cycles", budget);
  endtask

  task automatic measure_frame();
    int nb = 0, nh = 0, nv = 0, nk = 0, fh = -1, fv = -1;
    wait_fs(300);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) drive_cycle();
      if (!vga_blank_o) nb++;
      if (!vga_hsync_o) begin nh++; if (fh < 0) fh = i; end
      if (!vga_vsync_o) begin nv++; if (fv < 0) fv = i; end
      if (pix_ready_o && pix_valid_i) nk++;
      if (i == 5) chk("ramp_pixel5", {vga_red_o, vga_green_o, vga_blue_o}, 24'd5);
    end
    drive_cycle();
    chk("frame_period", frame_start_o, 1'b1);
    chk("active_cycles", nb, 32);
    chk("hsync_low_cycles", nh, 24);
    chk("vsync_low_cycles", nv, 30);
    chk("handshakes", nk, 32);
    chk("hsync_first", fh, 10);
    chk("vsync_first", fv, 75);
  endtask

  // ---------------- stimulus ----------------
  int t0, nbusy;
  bit und_seen;

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_en = 1'b1;
    chk("rst_blank", vga_blank_o, 1'b1);
    chk("rst_hsync", vga_hsync_o, 1'b1);
    chk("rst_vsync", vga_vsync_o, 1'b1);
    chk("rst_rgb", {vga_red_o, vga_green_o, vga_blue_o}, 24'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_underflow", underflow_o, 1'b0);
    rst_i = 1'b0;
    repeat (4) drive_cycle();
    chk("idle_ready", pix_ready_o, 1'b0);
    chk("idle_blank", vga_blank_o, 1'b1);

    // start with a ramp source
    valid_mode = 2;
    drive_cycle();
    enable_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("first_frame_start", frame_start_o, 1'b1);
    measure_frame();

    // three-cycle drop at line 2, pixel 3
    valid_mode = 0;
    wait_pos(0, 300);
    drop_en = 1'b1;
    wait_pos(2 * HT + 8, 300);
    drop_en = 1'b0;
    wait_pos(FRAME - 1, 300);
    chk("underflow_held", underflow_o, 1'b1);
    drive_cycle();
    drive_cycle();
    chk("fs_after_drop", frame_start_o, 1'b1);
    chk("underflow_cleared", underflow_o, 1'b0);

    // stop at line 2: drains to end of frame
    wait_pos(2 * HT, 300);
    enable_i = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 300; i++) begin
      drive_cycle();
      if (!busy_o) break;
      nbusy++;
    end
    chk("stop_busy_cycles", nbusy, 89);
    repeat (5) drive_cycle();
    chk("stopped_blank", vga_blank_o, 1'b1);
    chk("stopped_ready", pix_ready_o, 1'b0);

    // stop then re-enable inside the same frame
    enable_i = 1'b1;
    wait_fs(300);
    t0 = cyc;
    wait_pos(2 * HT, 300);
    enable_i = 1'b0;
    wait_pos(4 * HT, 300);
    enable_i = 1'b1;
    wait_fs(300);
    chk("restart_period", cyc - t0, FRAME);

    // randomized phase
    valid_mode = 1;
    rand_en = 1'b1;
    und_seen = 1'b0;
    repeat (2500) begin
      drive_cycle();
      if (underflow_o) und_seen = 1'b1;
    end
    rand_en = 1'b0;
    chk("random_underflow_seen", und_seen, 1'b1);

    // asynchronous reset in the middle of an active line
    valid_mode = 0;
    enable_i = 1'b1;
    wait_pos(HT + 4, 400);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ready", pix_ready_o, 1'b0);
    chk("arst_blank", vga_blank_o, 1'b1);
    chk("arst_rgb", {vga_red_o, vga_green_o, vga_blue_o}, 24'h0);
    chk("arst_hsync", vga_hsync_o, 1'b1);
    drive_cycle();
    drive_cycle();
    rst_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("arst_frame_start", frame_start_o, 1'b1);
    valid_mode = 1;
    repeat (200) drive_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Raster timing controller and pixel scheduler for the DVI output path. It generates hsync, vsync and blank from compile-time timing parameters. During active video it pulls one pixel per clock from an upstream pixel source over a valid/ready handshake, and drives registered RGB/sync/blank to the dvi encoder. It handles clean frame-aligned start/stop and reports underflow.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted level of sync outputs (0 = active-low)

Ports:
- clk_i  in  1  pixel clock; the only clock
- rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  request video output
- pix_valid_i  in  1  upstream pixel available
- pix_data_i  in  24  {R[23:16],G[15:8],B[7:0]}
- pix_ready_o  out  1  pixel consumed this cycle when pix_valid_i is also high
- vga_red_o / vga_green_o / vga_blue_o  out  8 each  pixel colour
- vga_blank_o  out  1  1 = outside active area
- vga_hsync_o / vga_vsync_o  out  1  syncs at configured polarity
- frame_start_o  out  1  one-cycle pulse, first cycle of a frame (h=0, v=0)
- busy_o  out  1  state != IDLE
- underflow_o  out  1  sticky; a pixel was needed and absent in the current or last frame

## Operation
- Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), 12 bits each.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - Order within each line/frame: active, front porch, sync, back porch.
  - h wraps to 0 and increments v; v wraps to 0 at the end of the last line.
- active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- hsync asserted when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v_cnt.
- FSM states:
  - IDLE: counters held at 0.
  - RUN: counters advance every clock.
  - STOPPING: counters advance until the frame ends.
- Transitions:
  - IDLE→RUN when enable_i=1. The first RUN cycle is h=0,v=0, and frame_start_o fires.
  - RUN→STOPPING when enable_i=0.
  - STOPPING→RUN if enable_i returns to 1 before the frame ends; no frame restart.
  - STOPPING→IDLE on the cycle h=H_TOTAL-1, v=V_TOTAL-1.
- Frames are never truncated.
- pix_ready_o = (state != IDLE) && active, combinational from the counters. Exactly one pull per active cycle.
- Underflow handling:
  - If active && !pix_valid_i, the output pixel is 0x000000 and underflow_o is set.
  - The raster does not stall and no pixel is consumed.
- underflow_o clears at each frame_start_o unless an underflow occurs in that same cycle; the set wins.
- While IDLE:
  - blank=1, syncs at inactive level, RGB=0, pix_ready_o=0.
  - pix_valid_i is ignored.
- Reset mid-frame forces IDLE immediately. Counters and all registered outputs return to their reset values; no frame completion.

## Timing
- Reset values:
  - vga_blank_o=1
  - vga_hsync_o=~HSYNC_POL, vga_vsync_o=~VSYNC_POL
  - RGB=0
  - frame_start_o=0, busy_o=0, underflow_o=0
- Latency: RGB, blank, hsync, vsync and frame_start_o are registered together, one clock after the counter state that produced them. All are mutually aligned.
- Handshake: pixel data is sampled on the clock edge where pix_valid_i && pix_ready_o, and appears on vga_*_o the next cycle.
- busy_o is combinational from the state.
- underflow_o is registered and updates the cycle after the underflowing pixel.

## Structure
- Shared package video_pkg holds:
  - the default timing constants (640x480@60 set above);
  - the 12-bit counter width;
  - the FSM state encoding (IDLE/RUN/STOPPING);
  - the RGB888 pixel packing offsets.
- One natural sub-module, video_timing_counter: the h/v counters plus active/hsync/vsync/last-cycle decode. The controller owns the FSM, handshake, underflow and output registers.

## Test plan
- Reset, then enable_i=1 with pix_valid_i=1 held:
  - frame_start_o pulses every 800×525=420000 cycles;
  - per line: 640 blank=0 cycles, then hsync low for 96 cycles starting 16 cycles after active ends;
  - vsync low on lines 490–491.
- Ramp source, pixel = h index: output RGB equals the input data one cycle after each accepted beat; 307200 handshakes per frame.
- Drop pix_valid_i for 3 cycles at line 10, pixel 100:
  - RGB=0 for those 3 output cycles and the raster is not shifted;
  - underflow_o=1 until the next frame_start_o, then 0 when the following frame is clean.
- Deassert enable_i at line 200: busy_o stays 1 to the end of the frame; IDLE entered after h=799,v=524; blank=1 thereafter.
- Reassert enable_i during STOPPING: frame continues without a frame_start_o, and the next frame starts normally.
- Assert rst_i asynchronously mid-active-line: outputs reach reset values immediately and pix_ready_o=0. After release with enable_i=1, the next frame starts at h=0,v=0.
